// File: rtl/bootrom_pkg.sv
// Shared types and constants for the boot ROM port arbiter.
// FSM state encoding, grant ids and ROM geometry.
package bootrom_pkg;

  localparam int ROM_ADDR_W = 9;
  localparam int ROM_DATA_W = 32;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REJECT
  } state_t;

endpackage

// File: rtl/bootrom_rr_arbiter.sv
// Two-way round-robin arbiter for the boot ROM port.
// Ports: req[1:0] (bit0=i, bit1=d), last_grant, en -> one-hot gnt.
module bootrom_rr_arbiter
  import bootrom_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        // Tie goes to whoever did not win last time.
        if (last_grant == GNT_D) gnt = 2'b01;
        else                     gnt = 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/bootrom_port_arbiter.sv
// Shares one boot ROM read port between fetch (i) and data (d).
// Ports: i/d req-ack pairs, ROM en/addr/do, err_count of rejects.
module bootrom_port_arbiter
  import bootrom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_do,
  output logic [7:0]        err_count
);

  state_t            state;
  logic              last_grant;
  logic              cur;
  logic [1:0]        gnt;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              d_err_q;
  logic [DATA_W-1:0] i_data_q;
  logic [DATA_W-1:0] d_data_q;

  logic unused_bits;
  assign unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

  bootrom_rr_arbiter u_arb (
    .req        ({d_req, i_req}),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      cur        <= GNT_I;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_data_q   <= '0;
      d_data_q   <= '0;
      err_count  <= '0;
    end else begin
      rom_en  <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt[GNT_I]) begin
            rom_addr   <= i_addr[ADDR_W+1:2];
            cur        <= GNT_I;
            last_grant <= GNT_I;
            rom_en     <= 1'b1;
            state      <= ISSUE;
          end else if (gnt[GNT_D]) begin
            cur        <= GNT_D;
            last_grant <= GNT_D;
            if (d_we) begin
              d_ack_q  <= 1'b1;
              d_err_q  <= 1'b1;
              d_data_q <= '0;
              state    <= REJECT;
            end else begin
              rom_addr <= d_addr[ADDR_W+1:2];
              rom_en   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cur == GNT_I) i_ack_q <= 1'b1;
          else              d_ack_q <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (cur == GNT_I) i_data_q <= rom_do;
          else              d_data_q <= rom_do;
          state <= IDLE;
        end
        REJECT: begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state <= IDLE;
        end
      endcase
    end
  end

  // A reset landing in WAIT must swallow the in-flight ack.
  assign i_ack  = i_ack_q & ~rst;
  assign d_ack  = d_ack_q & ~rst;
  assign d_err  = d_err_q & ~rst;

  // ROM data passes through in the ack cycle, then is held.
  assign i_data = i_ack ? rom_do : i_data_q;
  assign d_data = (d_ack && !d_err) ? rom_do : d_data_q;

endmodule

// File: doc/bootrom_port_arbiter.md
# bootrom_port_arbiter

Shares one synchronous read port of the 512x32 boot ROM between the instruction-fetch path and the data path. Each requester uses a req/ack handshake. Round-robin arbitration decides simultaneous requests. Data-side writes are rejected with an error and never reach the ROM. The block sits between the CPU memory interfaces and one ROM port (en/addr/do, one-cycle read latency).

## Interface
- ADDR_W, 9: ROM word-address width (512 words).
- DATA_W, 32: ROM data width.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  32  instruction byte address; only [ADDR_W+1:2] used
- i_ack  out  1  one-cycle pulse, i_data valid
- i_data  out  DATA_W  read data, valid only with i_ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  data request is a write (illegal on ROM)
- d_addr  in  32  data byte address; only [ADDR_W+1:2] used
- d_ack  out  1  one-cycle pulse completing the data request
- d_err  out  1  with d_ack: request was a write, rejected
- d_data  out  DATA_W  read data, valid with d_ack when d_err=0
- rom_en  out  1  ROM port enable
- rom_addr  out  ADDR_W  ROM word address
- rom_do  in  DATA_W  ROM output, valid the cycle after rom_en sampled
- err_count  out  8  saturating count of rejected writes

## Operation
- FSM states: IDLE, ISSUE, WAIT, REJECT.
- **IDLE**
  - No request: stay in IDLE.
  - Grant selection: if only one req is high, grant it. If both are high, grant the one not in last_grant.
  - Granted i, or granted d with d_we=0: latch the requester's addr[ADDR_W+1:2] into rom_addr, set last_grant, go to ISSUE.
  - Granted d with d_we=1: set last_grant, go to REJECT.
- **ISSUE**: rom_en=1. Go to WAIT.
- **WAIT**
  - rom_en=0.
  - Drive the granted requester's data output from rom_do (i_data or d_data).
  - Pulse the granted requester's ack.
  - Go to IDLE.
- **REJECT**
  - d_ack=1, d_err=1, d_data=0. No ROM access occurs.
  - err_count increments, saturating at 8'hFF.
  - Go to IDLE.
- Requester rule: req, addr and we must stay stable from assertion until ack.
  - A req still high in the cycle after ack is a new transaction and is re-arbitrated in IDLE.
- Address bits above ADDR_W+1 and bits [1:0] are ignored. No alignment or range error is raised.
- i_data and d_data are registered. They hold their last value outside ack, but are defined only with ack.
- The non-granted requester sees no ack. Its req is held and it wins the next arbitration.

## Timing
- Reset values:
  - FSM = IDLE; last_grant = d, so i wins the first tie.
  - rom_en = 0, rom_addr = 0.
  - i_ack = d_ack = d_err = 0.
  - i_data = d_data = 0, err_count = 0.
- Read latency, with req first seen in IDLE at cycle N:
  - N+1: rom_en=1, rom_addr valid.
  - N+2: ROM data returns; ack in the same cycle.
  - N+3: back in IDLE. Throughput is one read per 3 cycles.
- Reject latency: req seen at N, d_ack/d_err at N+1, IDLE at N+2.
- Both reqs continuously high: grants alternate i, d, i, d… with no starvation.
- Reset asserted in ISSUE or WAIT:
  - Next cycle the FSM is IDLE; rom_en=0 and no ack is issued.
  - The in-flight ROM data is discarded.
  - The interrupted requester must re-present its request.
- rom_en is high for exactly one cycle per read transaction.

## Structure
- Shared package `bootrom_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, REJECT).
  - Grant id constants GNT_I=0, GNT_D=1.
  - ROM_ADDR_W=9 and ROM_DATA_W=32.
- One sub-module, `bootrom_rr_arbiter`: 2-way round-robin. Inputs are req[1:0], last_grant and an enable; output is a one-hot grant.
- Top level holds the FSM, the address/grant latch, the output registers and err_count.

## Test plan
- i_req=1, i_addr=32'h00000008, ROM model word 2=32'h504c502d, d_req=0 -> rom_en=1 with rom_addr=9'd2 at N+1; i_ack=1 with i_data=32'h504c502d at N+2; d_ack never asserted.
- i_req and d_req rise in the same cycle, both reads (i_addr=0, d_addr=32'h0000000C) -> i served first with rom_addr=0, then d with rom_addr=3. Ack order is i then d, 3 cycles apart.
- Both reqs held high for 12 transactions -> exactly 6 i_ack and 6 d_ack, strictly alternating.
- d_req=1, d_we=1, d_addr=32'h00000010 -> d_ack=d_err=1 at N+1; rom_en stays 0 throughout; err_count 0->1. Repeated 300 times -> err_count saturates at 8'hFF.
- rst asserted in the WAIT cycle of an i read -> no i_ack, FSM in IDLE, all outputs at reset values. A re-presented request completes normally 2 cycles after it is seen.
- i_addr=32'hFFFF_F804 -> rom_addr=9'd1 (upper and low bits ignored); read completes without error.
